// File: rtl/alu_sequencer_pkg.sv
// Shared types and constants for the ALU request sequencer: FSM states,
// op encodings, queue entry layout and the reference result function.
package alu_sequencer_pkg;

   localparam int DATA_W = 4;
   localparam int TAG_W  = 2;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } seq_state_t;

   typedef struct packed {
      logic              op;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [TAG_W-1:0]  tag;
   } req_entry_t;

   localparam int ENTRY_W = $bits(req_entry_t);

   // Result the ALU must return; carry and borrow are dropped (mod 16).
   function automatic logic [DATA_W-1:0] expected_result(input logic              op,
                                                          input logic [DATA_W-1:0] a,
                                                          input logic [DATA_W-1:0] b);
      logic [DATA_W-1:0] res_s;
      case (op)
         OP_ADD:  res_s = a + b;
         OP_SUB:  res_s = a - b;
         default: res_s = {DATA_W{1'b0}};
      endcase
      return res_s;
   endfunction

endpackage

// File: rtl/seq_fifo.sv
// Request queue for the ALU sequencer. Pointers carry one extra wrap bit so
// full and empty are distinguishable; ready is registered and low in reset.
module seq_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             empty,
   output logic             ready
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;
   logic [AW:0]      wr_ptr_nxt_s;
   logic [AW:0]      rd_ptr_nxt_s;
   logic             push_ok_s;
   logic             pop_ok_s;
   logic             full_nxt_s;
   logic             ready_r;

   assign push_ok_s = push & ready_r;
   assign pop_ok_s  = pop & ~empty;
   assign empty     = (wr_ptr_r == rd_ptr_r);
   assign pop_data  = mem_r[rd_ptr_r[AW-1:0]];
   assign ready     = ready_r;

   // Next pointer values and the full flag they imply.
   always_comb begin
      wr_ptr_nxt_s = wr_ptr_r;
      rd_ptr_nxt_s = rd_ptr_r;
      if (push_ok_s) begin
         wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
      end else begin
         wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_ok_s) begin
         rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
      end else begin
         rd_ptr_nxt_s = rd_ptr_r;
      end
      full_nxt_s = (wr_ptr_nxt_s[AW] != rd_ptr_nxt_s[AW]) &&
                   (wr_ptr_nxt_s[AW-1:0] == rd_ptr_nxt_s[AW-1:0]);
   end

   // Pointer and ready registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_r <= {(AW+1){1'b0}};
         rd_ptr_r <= {(AW+1){1'b0}};
         ready_r  <= 1'b0;
      end else begin
         wr_ptr_r <= wr_ptr_nxt_s;
         rd_ptr_r <= rd_ptr_nxt_s;
         ready_r  <= ~full_nxt_s;
      end
   end

   // Entry storage.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
      end else if (push_ok_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/alu_sequencer.sv
// Queues add/sub requests, issues them to an external registered ALU one at a
// time, checks each result against a local reference and returns it tagged.
module alu_sequencer
   import alu_sequencer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_op,
   input  logic [DATA_W-1:0] req_a,
   input  logic [DATA_W-1:0] req_b,
   input  logic [TAG_W-1:0]  req_tag,
   output logic              instruction,
   output logic [DATA_W-1:0] inputA,
   output logic [DATA_W-1:0] inputB,
   input  logic [DATA_W-1:0] alu_out,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [TAG_W-1:0]  rsp_tag,
   output logic              rsp_err,
   output logic [7:0]        err_count
);

   seq_state_t        state_r;
   seq_state_t        state_nxt_s;
   logic              pop_s;
   logic              fifo_empty_s;
   req_entry_t        push_entry_s;
   req_entry_t        head_s;
   logic              op_r;
   logic [DATA_W-1:0] a_r;
   logic [DATA_W-1:0] b_r;
   logic [TAG_W-1:0]  tag_r;
   logic              rsp_valid_r;
   logic [DATA_W-1:0] rsp_data_r;
   logic [TAG_W-1:0]  rsp_tag_r;
   logic              rsp_err_r;
   logic [7:0]        err_count_r;
   logic              rsp_fire_s;

   assign push_entry_s = {req_op, req_a, req_b, req_tag};
   assign rsp_fire_s   = rsp_valid_r & rsp_ready;

   seq_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (req_valid),
      .push_data (push_entry_s),
      .pop       (pop_s),
      .pop_data  (head_s),
      .empty     (fifo_empty_s),
      .ready     (req_ready)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next state; the queue head is popped whenever a new issue begins.
   always_comb begin
      state_nxt_s = state_r;
      pop_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (!fifo_empty_s) begin
               state_nxt_s = ST_ISSUE;
               pop_s       = 1'b1;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ISSUE: state_nxt_s = ST_WAIT;
         ST_WAIT:  state_nxt_s = ST_RESP;
         ST_RESP: begin
            if (rsp_ready && !fifo_empty_s) begin
               state_nxt_s = ST_ISSUE;
               pop_s       = 1'b1;
            end else if (rsp_ready) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_RESP;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Operand registers double as the ALU drive and hold between issues.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_r  <= OP_ADD;
         a_r   <= {DATA_W{1'b0}};
         b_r   <= {DATA_W{1'b0}};
         tag_r <= {TAG_W{1'b0}};
      end else if (pop_s) begin
         op_r  <= head_s.op;
         a_r   <= head_s.a;
         b_r   <= head_s.b;
         tag_r <= head_s.tag;
      end
   end

   // Response capture; fields only change while leaving WAIT, so they hold under stall.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rsp_valid_r <= 1'b0;
         rsp_data_r  <= {DATA_W{1'b0}};
         rsp_tag_r   <= {TAG_W{1'b0}};
         rsp_err_r   <= 1'b0;
      end else if (state_r == ST_WAIT) begin
         rsp_valid_r <= 1'b1;
         rsp_data_r  <= alu_out;
         rsp_tag_r   <= tag_r;
         rsp_err_r   <= (alu_out != expected_result(op_r, a_r, b_r));
      end else if (rsp_fire_s) begin
         rsp_valid_r <= 1'b0;
      end
   end

   // Saturating count of erroneous responses, counted at hand-off.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_count_r <= 8'd0;
      end else if (rsp_fire_s && rsp_err_r && (err_count_r != 8'hFF)) begin
         err_count_r <= err_count_r + 8'd1;
      end
   end

   assign instruction = op_r;
   assign inputA      = a_r;
   assign inputB      = b_r;
   assign rsp_valid   = rsp_valid_r;
   assign rsp_data    = rsp_data_r;
   assign rsp_tag     = rsp_tag_r;
   assign rsp_err     = rsp_err_r;
   assign err_count   = err_count_r;

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, request-queue entries (power of two, 2..16).
REQ-002 clk  input  1  sole clock, all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  request-offered flag.
REQ-005 req_ready  output  1  queue can accept a request this cycle.
REQ-006 req_op  input  1  0 = add (A+B), 1 = subtract (A-B).
REQ-007 req_a, req_b  input  4 each  operands.
REQ-008 req_tag  input  2  caller tag, returned unchanged.
REQ-009 instruction  output  1  op driven to the ALU.
REQ-010 inputA, inputB  output  4 each  operands driven to the ALU.
REQ-011 alu_out  input  4  registered ALU result, valid one clock after the operands.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  consumer accepts the response.
REQ-014 rsp_data  output  4  captured alu_out.
REQ-015 rsp_tag  output  2  tag of the completed request.
REQ-016 rsp_err  output  1  alu_out differed from the internally computed expected value.
REQ-017 err_count  output  8  saturating mismatch counter.

Function
REQ-018 A request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1.
REQ-019 Accepted requests SHALL be stored in a FIFO of DEPTH entries, each entry holding op, a, b and tag.
REQ-020 req_ready SHALL be 1 exactly when the FIFO is not full; a push and a pop in the same cycle while full SHALL be disallowed, because req_ready is 0.
REQ-021 The FSM SHALL use the states IDLE, ISSUE, WAIT and RESP.
REQ-022 IDLE->ISSUE SHALL occur when the FIFO is non-empty; the head entry is popped on that edge and latched into operand registers.
REQ-023 In ISSUE, instruction/inputA/inputB SHALL present the latched op/a/b for exactly one cycle, then the FSM moves to WAIT.
REQ-024 In WAIT, the block SHALL capture alu_out into rsp_data and set rsp_err = (alu_out != expected), then move to RESP.
REQ-025 The expected value SHALL be (a+b) mod 16 for op 0 and (a-b) mod 16 for op 1, with no carry or borrow output.
REQ-026 In RESP, rsp_valid SHALL be 1; on rsp_ready=1 the FSM moves to ISSUE if the FIFO is non-empty (popping on the same edge), else to IDLE.
REQ-027 rsp_data, rsp_tag and rsp_err SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-028 Outside ISSUE, instruction/inputA/inputB SHALL hold their last driven value (0 after reset).
REQ-029 err_count SHALL increment once per completed response with rsp_err=1, saturate at 255, and never wrap.
REQ-030 Minimum latency SHALL be accept at edge N, ISSUE in cycle N+1, WAIT in N+2, rsp_valid from N+3; back-to-back throughput is one result per 3 cycles.
REQ-031 A push into an empty FIFO while in IDLE SHALL NOT bypass the FIFO; it is issued on the following edge.
REQ-032 Simultaneous push and pop SHALL be legal whenever not full; occupancy is unchanged.
REQ-033 FIFO pointers SHALL wrap modulo DEPTH, and full/empty SHALL be tracked with an extra pointer bit.

Reset
REQ-034 Asserting reset SHALL immediately clear the FSM to IDLE, empty the FIFO, and zero req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err, err_count, instruction, inputA and inputB.
REQ-035 After deassertion, req_ready SHALL go to 1 on the first clock.
REQ-036 A reset mid-operation SHALL discard all in-flight and queued requests with no response produced.

Structure
REQ-037 A shared package SHALL hold the FSM state enum, the op encodings OP_ADD=0 and OP_SUB=1, and the data width constant 4.
REQ-038 The FIFO SHALL be the single sub-module, seq_fifo, parameterised by DEPTH and entry width; the FSM, expected-value logic and counter stay in alu_sequencer.
REQ-039 The bench SHALL connect alu_sequencer to the ALU netlist for integration runs and to a behavioural faulty ALU model for error runs.

Verification
REQ-040 Single add: op=0, a=7, b=5, tag=1 -> rsp_valid 3 cycles after accept, rsp_data=0xC, rsp_tag=1, rsp_err=0.
REQ-041 Sub wrap: op=1, a=2, b=5 -> rsp_data=0xD, rsp_err=0; add a=9, b=9 -> rsp_data=0x2.
REQ-042 Full/backpressure: rsp_ready=0, push 5 requests with DEPTH=4 -> req_ready=0 after the 4th queued request (one in flight); tags return in order once rsp_ready=1.
REQ-043 Error count: faulty model returns 0 for 300 requests -> rsp_err=1 on each non-zero-expected case and err_count saturates at 255.
REQ-044 Reset mid-WAIT with 2 queued requests -> no rsp_valid after release, req_ready=1 on the first edge, outputs zero.
REQ-045 Random back-to-back stream with rsp_ready toggled randomly -> every response matches the scoreboard, no loss or duplication, rsp fields stable under stall.
